mips_multicycle_control: RTL and testbench

Moore-FSM control unit for the multi-cycle successor of the single-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several cycles and stalls on a memory ready handshake. It runs the floating-point adder over a parametrised multi-cycle latency. It drives the shared-memory, IR, PC, ALU, register-file and floating-mux selects of the multi-cycle datapath, and reports retirement and illegal-opcode events.

---
 rtl/mips_multicycle_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Moore-FSM control unit for a multi-cycle MIPS datapath.
//            Sequences fetch/decode/execute/memory/writeback, stalls on the
//            memory ready handshake, and holds FP_EX for FP_LATENCY cycles
//            while the floating-point adder completes.
// Ports    : clk, rst           - clock and synchronous active-high reset
//            opcode             - IR[31:26], consulted in DECODE and MEMADR
//            mem_ready          - memory completes the current access
//            pc_write, pc_write_cond, pc_source       - PC update controls
//            i_or_d, mem_read, mem_write, ir_write    - memory / IR controls
//            reg_dst, mem_to_reg, reg_write           - register file controls
//            alu_src_a, alu_src_b, alu_op, floating   - execute controls
//            instr_retired, illegal                   - event pulses
//            state                                    - debug state encoding
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_control #(
    parameter int          FP_LATENCY = 3,
    parameter bit          ENABLE_FP  = 1'b1,
    parameter logic [5:0]  FP_OPCODE  = 6'b010001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       floating,
    output logic       instr_retired,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // Counter only has to hold FP_LATENCY-1.
    localparam int c_CNT_W = (FP_LATENCY > 1) ? $clog2(FP_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_FP_LOAD = c_CNT_W'(FP_LATENCY - 1);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_FP_EX   = 4'd12,
        S_FP_WB   = 4'd13,
        S_ILLEGAL = 4'd14,
        S_UNUSED  = 4'd15
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_fp_cnt;

    // ------------------------------------------------------------------
    // State register and FP latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_fp_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && w_next == S_FP_EX) begin
                r_fp_cnt <= c_FP_LOAD;
            end else if (r_state == S_FP_EX && r_fp_cnt != '0) begin
                r_fp_cnt <= r_fp_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs. Only FETCH's ir_write/pc_write and
    // MEMWR's instr_retired look at mem_ready. Reset blanks everything so
    // an aborted instruction can never write the PC or register file.
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        floating      = 1'b0;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        state         = r_state;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_ADDI:        w_next = S_ADDI_EX;
                    default: begin
                        if (ENABLE_FP && opcode == FP_OPCODE) begin
                            w_next = S_FP_EX;
                        end else begin
                            w_next = S_ILLEGAL;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                w_next   = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMWR: begin
                mem_write     = 1'b1;
                i_or_d        = 1'b1;
                instr_retired = mem_ready;
                w_next        = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_retired = 1'b1;
            end
            S_JUMP: begin
                pc_write      = 1'b1;
                pc_source     = 2'b10;
                instr_retired = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_FP_EX: begin
                alu_src_a = 1'b1;
                floating  = 1'b1;
                // Counter was loaded with FP_LATENCY-1 on entry.
                w_next    = (r_fp_cnt == '0) ? S_FP_WB : S_FP_EX;
            end
            S_FP_WB: begin
                reg_dst       = 1'b1;
                floating      = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            S_ILLEGAL: begin
                illegal       = 1'b1;
                instr_retired = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            floating      = 1'b0;
            instr_retired = 1'b0;
            illegal       = 1'b0;
            state         = 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_control
// Purpose  : Directed self-checking bench for mips_multicycle_control.
//            dut_fp runs the default configuration; dut_nofp has the FP
//            instruction disabled so that it must decode as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;

    logic       clk;
    logic       rst;
    logic       rst2;
    logic [5:0] opcode;
    logic [5:0] opcode2;
    logic       mem_ready;

    logic       pw1, pwc1, iod1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1, fl1, ret1, ill1;
    logic [1:0] asb1, aop1, ps1;
    logic [3:0] st1;
    logic       pw2, pwc2, iod2, mr2, mw2, irw2, rd2, m2r2, rw2, asa2, fl2, ret2, ill2;
    logic [1:0] asb2, aop2, ps2;
    logic [3:0] st2;

    logic [18:0] ctrl1;
    logic [18:0] ctrl2;
    assign ctrl1 = {pw1, pwc1, iod1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1,
                    asb1, aop1, ps1, fl1, ret1, ill1};
    assign ctrl2 = {pw2, pwc2, iod2, mr2, mw2, irw2, rd2, m2r2, rw2, asa2,
                    asb2, aop2, ps2, fl2, ret2, ill2};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    mips_multicycle_control #(
        .FP_LATENCY (3),
        .ENABLE_FP  (1'b1),
        .FP_OPCODE  (6'b010001)
    ) dut_fp (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pw1), .pc_write_cond(pwc1), .i_or_d(iod1), .mem_read(mr1),
        .mem_write(mw1), .ir_write(irw1), .reg_dst(rd1), .mem_to_reg(m2r1),
        .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1),
        .pc_source(ps1), .floating(fl1), .instr_retired(ret1), .illegal(ill1),
        .state(st1)
    );

    mips_multicycle_control #(
        .FP_LATENCY (3),
        .ENABLE_FP  (1'b0),
        .FP_OPCODE  (6'b010001)
    ) dut_nofp (
        .clk(clk), .rst(rst2), .opcode(opcode2), .mem_ready(mem_ready),
        .pc_write(pw2), .pc_write_cond(pwc2), .i_or_d(iod2), .mem_read(mr2),
        .mem_write(mw2), .ir_write(irw2), .reg_dst(rd2), .mem_to_reg(m2r2),
        .reg_write(rw2), .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2),
        .pc_source(ps2), .floating(fl2), .instr_retired(ret2), .illegal(ill2),
        .state(st2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc_no, act, exp);
        end
    endtask

    // Hand-written control table. Field order:
    // pw pwc iod mr mw irw rd m2r rw asa | asb aop ps | fl ret ill
    function automatic logic [18:0] exp_ctrl(input logic [3:0] s, input logic mrdy);
        logic [18:0] e;
        case (s)
            4'd0:  e = {mrdy, 1'b0, 1'b0, 1'b1, 1'b0, mrdy, 4'b0000, 2'b01, 2'b00, 2'b00, 3'b000};
            4'd1:  e = {10'b0, 2'b11, 2'b00, 2'b00, 3'b000};
            4'd2:  e = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 3'b000};
            4'd3:  e = {2'b00, 1'b1, 1'b1, 6'b0, 6'b0, 3'b000};
            4'd4:  e = {7'b0, 1'b1, 1'b1, 1'b0, 6'b0, 3'b010};
            4'd5:  e = {2'b00, 1'b1, 1'b0, 1'b1, 5'b0, 6'b0, 1'b0, mrdy, 1'b0};
            4'd6:  e = {9'b0, 1'b1, 2'b00, 2'b10, 2'b00, 3'b000};
            4'd7:  e = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0, 3'b010};
            4'd8:  e = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 3'b010};
            4'd9:  e = {1'b1, 9'b0, 2'b00, 2'b00, 2'b10, 3'b010};
            4'd10: e = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 3'b000};
            4'd11: e = {8'b0, 1'b1, 1'b0, 6'b0, 3'b010};
            4'd12: e = {9'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b100};
            4'd13: e = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0, 3'b110};
            4'd14: e = {10'b0, 6'b0, 3'b011};
            default: e = 19'b0;
        endcase
        return e;
    endfunction

    // Called just after a rising edge: apply mem_ready, check mid-cycle,
    // then advance to just after the next rising edge.
    task automatic cyc(input int which, input logic [3:0] exp_state, input logic mrdy);
        mem_ready = mrdy;
        #4;
        if (which == 1) begin
            check("state", 32'(st1), 32'(exp_state));
            check("ctrl",  32'(ctrl1), 32'(exp_ctrl(exp_state, mrdy)));
        end else begin
            check("state_nofp", 32'(st2), 32'(exp_state));
            check("ctrl_nofp",  32'(ctrl2), 32'(exp_ctrl(exp_state, mrdy)));
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic reset_cyc(input logic mrdy);
        mem_ready = mrdy;
        #4;
        check("rst_state", 32'(st1), 32'd0);
        check("rst_ctrl",  32'(ctrl1), 32'd0);
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    logic saw_rw;
    int   ret_cnt;

    initial begin
        rst       = 1'b1;
        rst2      = 1'b1;
        opcode    = 6'b100011;
        opcode2   = 6'b010001;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held for two cycles; outputs blanked even with mem_ready=1.
        reset_cyc(1'b1);
        reset_cyc(1'b1);
        rst = 1'b0;

        // lw, no stalls: 0,1,2,3,4 then FETCH; single retire pulse.
        opcode  = 6'b100011;
        ret_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) ret_cnt += int'(ret1);
            cyc(1, 4'(i), 1'b1);
        end
        check("lw_retire_in_wb", 32'(ret_cnt), 32'd1);

        // lw with stalls: FETCH 4 cycles, MEMRD 3 cycles, 10 cycles total.
        cyc(1, 4'd0, 1'b0);
        cyc(1, 4'd0, 1'b0);
        cyc(1, 4'd0, 1'b0);
        cyc(1, 4'd0, 1'b1);
        cyc(1, 4'd1, 1'b1);
        cyc(1, 4'd2, 1'b1);
        cyc(1, 4'd3, 1'b0);
        cyc(1, 4'd3, 1'b0);
        cyc(1, 4'd3, 1'b1);
        cyc(1, 4'd4, 1'b0);

        // sw with one MEMWR stall: retire only when mem_ready.
        opcode = 6'b101011;
        cyc(1, 4'd0, 1'b1);
        cyc(1, 4'd1, 1'b0);
        cyc(1, 4'd2, 1'b0);
        cyc(1, 4'd5, 1'b0);
        cyc(1, 4'd5, 1'b1);

        // R-type and addi.
        opcode = 6'b000000;
        cyc(1, 4'd0, 1'b1); cyc(1, 4'd1, 1'b1); cyc(1, 4'd6, 1'b1); cyc(1, 4'd7, 1'b1);
        opcode = 6'b001000;
        cyc(1, 4'd0, 1'b1); cyc(1, 4'd1, 1'b1); cyc(1, 4'd10, 1'b1); cyc(1, 4'd11, 1'b1);

        // FP add: FP_EX exactly 3 cycles, then FP_WB; 6 cycles total.
        opcode = 6'b010001;
        cyc(1, 4'd0, 1'b1); cyc(1, 4'd1, 1'b1);
        cyc(1, 4'd12, 1'b1); cyc(1, 4'd12, 1'b0); cyc(1, 4'd12, 1'b1);
        cyc(1, 4'd13, 1'b1);

        // beq then j.
        opcode = 6'b000100;
        cyc(1, 4'd0, 1'b1); cyc(1, 4'd1, 1'b1); cyc(1, 4'd8, 1'b1);
        opcode = 6'b000010;
        cyc(1, 4'd0, 1'b1); cyc(1, 4'd1, 1'b1); cyc(1, 4'd9, 1'b1);

        // Unknown opcode.
        opcode = 6'b111111;
        cyc(1, 4'd0, 1'b1); cyc(1, 4'd1, 1'b1); cyc(1, 4'd14, 1'b1);

        // Reset while stalled in MEMRD aborts the load with no write.
        opcode = 6'b100011;
        saw_rw = 1'b0;
        cyc(1, 4'd0, 1'b1); cyc(1, 4'd1, 1'b1); cyc(1, 4'd2, 1'b1);
        saw_rw |= rw1;
        cyc(1, 4'd3, 1'b0);
        saw_rw |= rw1;
        cyc(1, 4'd3, 1'b0);
        rst = 1'b1;
        #4;
        saw_rw |= rw1;
        reset_cyc(1'b0);
        rst = 1'b0;
        saw_rw |= rw1;
        cyc(1, 4'd0, 1'b1);
        saw_rw |= rw1;
        check("abort_no_reg_write", 32'(saw_rw), 32'd0);

        // ENABLE_FP=0: FP opcode decodes as illegal, no reg_write.
        rst2 = 1'b0;
        opcode2 = 6'b010001;
        cyc(2, 4'd0, 1'b1);
        cyc(2, 4'd1, 1'b1);
        check("nofp_illegal", 32'(ill2), 32'd1);
        cyc(2, 4'd14, 1'b1);
        cyc(2, 4'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
